// File: rtl/sprite_plot_sink.sv
// sprite_plot_sink: consumer end of the sprite-draw coordinate stream.
// Enables the sprite coordinate generator, accepts its (x,y) counts, pairs each
// with the sprite ROM colour, offsets by the target cell origin, drops
// transparent/off-screen pixels and drives the VGA adapter plot interface.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   start                one-cycle draw request (honoured only in IDLE)
//   origin_x/origin_y    screen position of sprite pixel (0,0), latched on start
//   key_en               transparency keying enable, latched on start
//   draw_enable          enable to the coordinate generator (high in STREAM)
//   gen_x/gen_y/gen_done coordinate generator counts and finished flag
//   rom_colour           sprite ROM data, ROM_LAT cycles after the coordinate
//   vga_x/vga_y/vga_colour/vga_plot  plot interface; data holds between plots
//   busy/done/error      status to the game controller
//   plotted_count        pixels plotted in the last or current draw (saturating)
module sprite_plot_sink #(
   parameter int unsigned SPR_W    = 47,
   parameter int unsigned SPR_H    = 52,
   parameter int unsigned ROM_LAT  = 1,
   parameter int unsigned COLOUR_W = 9,
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 240,
   parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0,
   parameter int unsigned WDOG     = SPR_W * SPR_H + 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [8:0]          origin_x,
   input  logic [7:0]          origin_y,
   input  logic                key_en,
   output logic                draw_enable,
   input  logic [5:0]          gen_x,
   input  logic [5:0]          gen_y,
   input  logic                gen_done,
   input  logic [COLOUR_W-1:0] rom_colour,
   output logic [8:0]          vga_x,
   output logic [7:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [11:0]         plotted_count
);

   localparam int unsigned WD_W = $clog2(WDOG + 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WDOG - 1);
   localparam logic [11:0]     NPIX     = 12'(SPR_W * SPR_H);
   localparam logic [1:0]      FL_LAST  = 2'(ROM_LAT);
   localparam logic [9:0]      SCR_W_L  = 10'(SCREEN_W);
   localparam logic [8:0]      SCR_H_L  = 9'(SCREEN_H);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DONE
   } state_t;

   state_t state, next_state;

   logic [8:0]      org_x_q;
   logic [7:0]      org_y_q;
   logic            key_q;
   logic [WD_W-1:0] wd_cnt;
   logic [1:0]      fl_cnt;
   logic            first_q;
   logic [5:0]      last_x, last_y;
   logic [11:0]     sample_count;
   logic [5:0]      px_q [ROM_LAT];
   logic [5:0]      py_q [ROM_LAT];
   logic            pv_q [ROM_LAT];

   logic       wd_trip_c, accept_c, plot_c, key_hit_c;
   logic       draw_enable_c, busy_c, done_c;
   logic [9:0] ax_c;
   logic [8:0] ay_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   assign wd_trip_c = (state == S_STREAM) && (wd_cnt == WD_LAST);

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (start) next_state = S_LOAD;
         S_LOAD:   next_state = S_STREAM;
         S_STREAM: if (gen_done || wd_trip_c) next_state = S_FLUSH;
         S_FLUSH:  if (fl_cnt == FL_LAST) next_state = S_DONE;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Status outputs decoded from the next state so they register in step with it
   always_comb begin
      draw_enable_c = 1'b0;
      busy_c        = 1'b0;
      done_c        = 1'b0;
      draw_enable_c = (next_state == S_STREAM);
      busy_c        = (next_state != S_IDLE);
      done_c        = (next_state == S_DONE);
   end

   // A held final coordinate (generator raising its done flag) is not resampled
   assign accept_c = (state == S_STREAM) && !gen_done &&
                     (first_q || (gen_x != last_x) || (gen_y != last_y));

   // Wide sums so an off-screen pixel is rejected instead of wrapping on-screen
   assign ax_c      = 10'(org_x_q) + 10'(px_q[ROM_LAT-1]);
   assign ay_c      = 9'(org_y_q) + 9'(py_q[ROM_LAT-1]);
   assign key_hit_c = key_q && (rom_colour == KEY_COLOUR);
   assign plot_c    = pv_q[ROM_LAT-1] && (ax_c < SCR_W_L) && (ay_c < SCR_H_L) && !key_hit_c;

   // Control counters, sample tracking and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         draw_enable  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         org_x_q      <= '0;
         org_y_q      <= '0;
         key_q        <= 1'b0;
         wd_cnt       <= '0;
         fl_cnt       <= '0;
         first_q      <= 1'b0;
         last_x       <= '0;
         last_y       <= '0;
         sample_count <= '0;
      end else begin
         draw_enable <= draw_enable_c;
         busy        <= busy_c;
         done        <= done_c;
         first_q     <= (state == S_LOAD);
         wd_cnt      <= (state == S_STREAM) ? wd_cnt + 1'b1 : '0;
         fl_cnt      <= (state == S_FLUSH) ? fl_cnt + 2'd1 : '0;

         if (state == S_IDLE && start) begin
            org_x_q      <= origin_x;
            org_y_q      <= origin_y;
            key_q        <= key_en;
            sample_count <= '0;
         end else if (accept_c) begin
            sample_count <= sample_count + 12'd1;
         end

         if (accept_c) begin
            last_x <= gen_x;
            last_y <= gen_y;
         end

         if (state == S_IDLE && start)
            error <= 1'b0;
         else if (wd_trip_c)
            error <= 1'b1;
         else if (state == S_FLUSH && next_state == S_DONE && sample_count != NPIX)
            error <= 1'b1;
      end
   end

   // Coordinate delay line aligning each accepted sample with its ROM colour
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ROM_LAT; i++) begin
            px_q[i] <= '0;
            py_q[i] <= '0;
            pv_q[i] <= 1'b0;
         end
      end else begin
         px_q[0] <= gen_x;
         py_q[0] <= gen_y;
         pv_q[0] <= accept_c;
         for (int unsigned i = 1; i < ROM_LAT; i++) begin
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
            pv_q[i] <= pv_q[i-1];
         end
      end
   end

   // Plot output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_x         <= '0;
         vga_y         <= '0;
         vga_colour    <= '0;
         vga_plot      <= 1'b0;
         plotted_count <= '0;
      end else begin
         vga_plot <= plot_c;
         if (plot_c) begin
            vga_x      <= ax_c[8:0];
            vga_y      <= ay_c[7:0];
            vga_colour <= rom_colour;
         end
         if (state == S_IDLE && start)
            plotted_count <= '0;
         else if (plot_c && plotted_count != 12'hFFF)
            plotted_count <= plotted_count + 12'd1;
      end
   end

endmodule
